// File: rtl/ad_pack_axis_if.sv
// rtl/ad_pack_axis_if.sv - input/output stream handshake bundle for the packing gearbox
interface ad_pack_axis_if #(
    parameter int I_W    = 4,
    parameter int O_W    = 6,
    parameter int UNIT_W = 8
);
    logic [I_W*UNIT_W-1:0] idata;
    logic                  ivalid;
    logic                  ilast;
    logic                  iready;
    logic [O_W*UNIT_W-1:0] odata;
    logic [O_W-1:0]        okeep;
    logic                  olast;
    logic                  ovalid;
    logic                  oready;

    // Gearbox side: consumes the input stream, produces the output stream.
    modport slave (
        input  idata, ivalid, ilast, oready,
        output iready, odata, okeep, olast, ovalid
    );

    // Environment side: feeds input beats and sinks output words.
    modport master (
        output idata, ivalid, ilast, oready,
        input  iready, odata, okeep, olast, ovalid
    );
endinterface

// File: rtl/ad_pack_axis.sv
// rtl/ad_pack_axis.sv - packs I_W-unit input words into O_W-unit output words with backpressure and last flush
module ad_pack_axis #(
    parameter int I_W    = 4,
    parameter int O_W    = 6,
    parameter int UNIT_W = 8,
    parameter int DEPTH  = 2 * (I_W + O_W)
) (
    input logic           clk,
    input logic           resetn,
    ad_pack_axis_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Unit 0 is always the oldest buffered unit; units at or above cnt are kept at zero.
    logic [UNIT_W-1:0] mem      [DEPTH];
    logic [UNIT_W-1:0] mem_next [DEPTH];
    logic [CW-1:0]     cnt;
    logic              flush_pend;
    logic              push;
    logic              pop;
    int                cnt_i;
    int                popped;
    int                base;
    int                src;

    // Handshake and output word are decoded from registered state only.
    always_comb begin
        cnt_i      = int'(cnt);
        bus.iready = resetn && !flush_pend && (cnt_i + I_W <= DEPTH);
        bus.ovalid = (cnt_i >= O_W) || (flush_pend && cnt_i > 0);
        bus.olast  = flush_pend && (cnt_i > 0) && (cnt_i <= O_W);
        bus.okeep  = '0;
        bus.odata  = '0;
        for (int k = 0; k < O_W; k++) begin
            if (k < cnt_i) begin
                bus.okeep[k]                  = 1'b1;
                bus.odata[k*UNIT_W +: UNIT_W] = mem[AW'(k)];
            end
        end
    end

    // Next buffer image: shift out the popped units, then append the new beat after the shift.
    always_comb begin
        push   = bus.ivalid && bus.iready;
        pop    = bus.ovalid && bus.oready;
        popped = !pop ? 0 : ((cnt_i < O_W) ? cnt_i : O_W);
        base   = cnt_i - popped;
        src    = 0;
        for (int i = 0; i < DEPTH; i++) begin
            src         = i + popped;
            mem_next[i] = (src < DEPTH) ? mem[AW'(src)] : '0;
            if (push) begin
                for (int j = 0; j < I_W; j++) begin
                    if (i == base + j) begin
                        mem_next[i] = bus.idata[j*UNIT_W +: UNIT_W];
                    end
                end
            end
        end
    end

    // State update: buffer contents, fill level and pending flush of a terminated packet.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt        <= '0;
            flush_pend <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= mem_next[i];
            end
            cnt <= CW'(base + (push ? I_W : 0));
            if (push && bus.ilast) begin
                flush_pend <= 1'b1;
            end else if (pop && bus.olast) begin
                flush_pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ad_pack_axis.sv
// tb/tb_ad_pack_axis.sv - directed self-checking bench for ad_pack_axis
module tb_ad_pack_axis;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   w;
    int   s;
    int   ib;
    int   ob;
    int   cb;
    int   fb;
    int   sb;
    bit   db;
    logic [31:0] eb;

    always #5 clk = ~clk;

    ad_pack_axis_if #(.I_W(4), .O_W(6), .UNIT_W(8)) ifa ();
    ad_pack_axis_if #(.I_W(6), .O_W(4), .UNIT_W(8)) ifb ();

    ad_pack_axis #(.I_W(4), .O_W(6), .UNIT_W(8), .DEPTH(20)) u_dut_a (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifa)
    );

    ad_pack_axis #(.I_W(6), .O_W(4), .UNIT_W(8), .DEPTH(20)) u_dut_b (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifb)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One packet of nbeats beats through dut A; byte n of the stream is b0+n.
    task automatic run_a(input int nbeats, input logic [7:0] b0, input int vpct, input int rpct,
                         input bit rdy_steady, output int words, output int span);
        int          in_beat;
        int          out_u;
        int          total;
        int          cyc;
        int          first;
        bit          flushing;
        bit          done;
        logic [47:0] exp_d;
        logic [5:0]  exp_k;
        logic        exp_l;
        in_beat  = 0;
        out_u    = 0;
        total    = nbeats * 4;
        cyc      = 0;
        first    = -1;
        flushing = 1'b0;
        done     = 1'b0;
        words    = 0;
        span     = 0;
        while (!done && cyc < 4000) begin
            ifa.ivalid = (in_beat < nbeats) && ($urandom_range(99) < vpct);
            for (int j = 0; j < 4; j++) ifa.idata[j*8 +: 8] = 8'(int'(b0) + in_beat * 4 + j);
            ifa.ilast  = (in_beat == nbeats - 1);
            ifa.oready = ($urandom_range(99) < rpct);
            @(negedge clk);
            if (flushing) chk("flush_iready_low", ifa.iready, 0);
            if (rdy_steady && in_beat < nbeats) chk("steady_iready_high", ifa.iready, 1);
            if (ifa.ovalid) begin
                if (first < 0) first = cyc;
                exp_d = '0;
                exp_k = '0;
                for (int k = 0; k < 6; k++) begin
                    if (out_u + k < total) begin
                        exp_d[k*8 +: 8] = 8'(int'(b0) + out_u + k);
                        exp_k[k]        = 1'b1;
                    end
                end
                exp_l = (out_u + 6 >= total);
                chk("odata", ifa.odata, exp_d);
                chk("okeep", ifa.okeep, exp_k);
                chk("olast", ifa.olast, exp_l);
                if (ifa.oready) begin
                    words++;
                    out_u += 6;
                    if (exp_l) begin
                        done     = 1'b1;
                        flushing = 1'b0;
                        span     = cyc - first + 1;
                    end
                end
            end
            if (ifa.ivalid && ifa.iready) begin
                if (ifa.ilast) flushing = 1'b1;
                in_beat++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("packet_done_in_budget", done, 1);
        ifa.ivalid = 1'b0;
        ifa.ilast  = 1'b0;
        ifa.oready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_extra_word", ifa.ovalid, 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        ifa.idata = '0; ifa.ivalid = 1'b0; ifa.ilast = 1'b0; ifa.oready = 1'b0;
        ifb.idata = '0; ifb.ivalid = 1'b0; ifb.ilast = 1'b0; ifb.oready = 1'b0;

        // Reset state
        #2;
        chk("rst_ovalid", ifa.ovalid, 0);
        chk("rst_olast", ifa.olast, 0);
        chk("rst_okeep", ifa.okeep, 0);
        chk("rst_odata", ifa.odata, 0);
        chk("rst_iready", ifa.iready, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // 20 units: three full words, then a 2-unit flush word
        run_a(5, 8'h00, 100, 100, 1'b0, w, s);
        chk("t3_words", w, 4);

        // 12 units: exact fit, two words, the second carries olast
        run_a(3, 8'h40, 100, 100, 1'b0, w, s);
        chk("t4_words", w, 2);

        // 1024 bytes, random ivalid, sink always ready
        run_a(256, 8'h00, 60, 100, 1'b0, w, s);
        chk("t1_words", w, 171);

        // Same stream with a stalling sink
        run_a(256, 8'h00, 60, 50, 1'b0, w, s);
        chk("t2_words", w, 171);

        // Reset mid-packet discards buffered data
        ifa.oready = 1'b0;
        ifa.ilast  = 1'b0;
        ifa.ivalid = 1'b1;
        for (int b = 0; b < 7; b++) begin
            for (int j = 0; j < 4; j++) ifa.idata[j*8 +: 8] = 8'(8'h80 + b * 4 + j);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("t5_ovalid_before_reset", ifa.ovalid, 1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("t5_ovalid_in_reset", ifa.ovalid, 0);
        chk("t5_iready_in_reset", ifa.iready, 0);
        chk("t5_odata_in_reset", ifa.odata, 0);
        ifa.ivalid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        run_a(3, 8'hA0, 100, 100, 1'b0, w, s);
        chk("t5_words_after_reset", w, 2);

        // Continuous flow, 600 beats: 4 units per cycle, iready never drops
        run_a(600, 8'h10, 100, 100, 1'b1, w, s);
        chk("t6_words", w, 400);
        chk("t6_span_le_605", (s <= 605), 1);

        // Wide-in / narrow-out instance: one full word every cycle
        ib = 0; ob = 0; cb = 0; fb = -1; db = 1'b0; sb = 0;
        while (!db && cb < 1000) begin
            ifb.ivalid = (ib < 60);
            for (int j = 0; j < 6; j++) ifb.idata[j*8 +: 8] = 8'(ib * 6 + j + 16);
            ifb.ilast  = (ib == 59);
            ifb.oready = 1'b1;
            @(negedge clk);
            if (ifb.ovalid) begin
                if (fb < 0) fb = cb;
                for (int k = 0; k < 4; k++) eb[k*8 +: 8] = 8'(ob + k + 16);
                chk("b_odata", ifb.odata, eb);
                chk("b_okeep", ifb.okeep, 4'hf);
                chk("b_olast", ifb.olast, (ob + 4 >= 360));
                ob += 4;
                if (ob >= 360) begin
                    db = 1'b1;
                    sb = cb - fb + 1;
                end
            end
            if (ifb.ivalid && ifb.iready) ib++;
            @(posedge clk);
            #1;
            cb++;
        end
        ifb.ivalid = 1'b0;
        ifb.ilast  = 1'b0;
        chk("b_done_in_budget", db, 1);
        chk("b_one_word_per_cycle", sb, 90);
        @(negedge clk);
        chk("b_no_extra_word", ifb.ovalid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
